// File: rtl/psx_pkg.sv
// Shared constants, state encoding and poll command table for the PSX pad-bus poll scheduler.
package psx_pkg;

    localparam logic [7:0] PSX_CMD_START  = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
    localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PSX_DATA_START = 8'h5A;
    localparam int         PSX_POLL_LEN   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_ACK_WAIT,
        ST_END,
        ST_GAP
    } psx_state_t;

    // Console bytes of the digital poll: 01 42 00 00 00.
    function automatic logic [7:0] psx_tx_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    psx_tx_byte = PSX_CMD_START;
            3'd1:    psx_tx_byte = PSX_CMD_POLL;
            default: psx_tx_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/psx_byte_xfer.sv
// One-byte PSX bus shifter: drives psx_clk/cmd LSB first and samples data on each psx_clk rise.
module psx_byte_xfer #(
    parameter int CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       data,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       psx_clk,
    output logic       cmd
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          busy_reg;
    logic [DW-1:0] div_reg;
    logic [2:0]    bit_reg;
    logic [7:0]    tx_reg;
    logic          half_end;

    assign half_end = (div_reg == DW'(CLK_DIV - 1));
    // Asserted during the last high cycle so the caller acts on the edge the next fall would use.
    assign done     = busy_reg && psx_clk && half_end && (bit_reg == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
            div_reg  <= '0;
            bit_reg  <= '0;
            tx_reg   <= '0;
            rx_byte  <= 8'hFF;
            psx_clk  <= 1'b1;
            cmd      <= 1'b1;
        end else if (start) begin
            busy_reg <= 1'b1;
            div_reg  <= '0;
            bit_reg  <= '0;
            tx_reg   <= tx_byte;
            psx_clk  <= 1'b0;
            cmd      <= tx_byte[0];
        end else if (busy_reg) begin
            if (!half_end) begin
                div_reg <= div_reg + DW'(1);
            end else begin
                div_reg <= '0;
                if (!psx_clk) begin
                    psx_clk <= 1'b1;
                    rx_byte <= {data, rx_byte[7:1]};
                end else if (bit_reg == 3'd7) begin
                    busy_reg <= 1'b0;
                    cmd      <= 1'b1;
                end else begin
                    psx_clk <= 1'b0;
                    bit_reg <= bit_reg + 3'd1;
                    cmd     <= tx_reg[bit_reg + 3'd1];
                end
            end
        end
    end

endmodule

// File: rtl/psx_poll_scheduler.sv
// PSX console-side poll sequencer: frame timer, per-port select, ack/timeout and result capture.
// Optional per-port error counters are built when PSX_ERR_CNT_EN is defined.
module psx_poll_scheduler
    import psx_pkg::*;
#(
    parameter int NPORTS      = 2,
    parameter int CLK_DIV     = 1,
    parameter int ATT_SETUP   = 2,
    parameter int ACK_TIMEOUT = 32,
    parameter int PORT_GAP    = 4,
    parameter int POLL_PERIOD = 4096,
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              data,
    input  logic              ack,
    output logic              psx_clk,
    output logic              cmd,
    output logic [NPORTS-1:0] att_n,
    output logic              btn_valid,
    output logic [PW-1:0]     btn_port,
    output logic [15:0]       btn_word,
    output logic [NPORTS-1:0] port_present
`ifdef PSX_ERR_CNT_EN
    ,
    output logic [8*NPORTS-1:0] err_cnt
`endif
);

    localparam int CMAX = (ATT_SETUP > ACK_TIMEOUT)
                        ? ((ATT_SETUP > PORT_GAP) ? ATT_SETUP : PORT_GAP)
                        : ((ACK_TIMEOUT > PORT_GAP) ? ACK_TIMEOUT : PORT_GAP);
    localparam int CW = $clog2(CMAX + 1);
    localparam int TW = $clog2(POLL_PERIOD + 1);

    psx_state_t    state_reg;
    logic [TW-1:0] timer_reg;
    logic [CW-1:0] cnt_reg;
    logic [PW-1:0] port_reg;
    logic [2:0]    byte_reg;
    logic          bad_reg;
    logic [7:0]    rx3_reg;

    logic          frame_start;
    logic          setup_done;
    logic          ack_go;
    logic          xfer_start;
    logic [2:0]    xfer_idx;
    logic          xfer_done;
    logic [7:0]    rx_byte;
    logic          id_bad;
    logic          finish_now;
    logic          finish_clean;
    logic          gap_done;
    logic          advance;

    assign frame_start  = enable && (timer_reg == TW'(POLL_PERIOD - 1));
    assign setup_done   = (state_reg == ST_SETUP) && (cnt_reg == CW'(ATT_SETUP - 1));
    assign ack_go       = (state_reg == ST_ACK_WAIT) && !ack;
    assign xfer_start   = setup_done || ack_go;
    assign xfer_idx     = ack_go ? (byte_reg + 3'd1) : 3'd0;
    assign id_bad       = ((byte_reg == 3'd1) && (rx_byte != PSX_ID_DIGITAL)) ||
                          ((byte_reg == 3'd2) && (rx_byte != PSX_DATA_START));
    assign finish_now   = ((state_reg == ST_XFER) && xfer_done && (byte_reg == 3'(PSX_POLL_LEN - 1))) ||
                          ((state_reg == ST_ACK_WAIT) && ack && (cnt_reg == CW'(ACK_TIMEOUT - 1)));
    // Only the last-byte path can be clean; a timeout exit is always a failed poll.
    assign finish_clean = (state_reg == ST_XFER) && !bad_reg;
    assign gap_done     = ((state_reg == ST_END) && (PORT_GAP <= 1)) ||
                          ((state_reg == ST_GAP) && (cnt_reg == CW'(PORT_GAP - 1)));
    assign advance      = enable && (port_reg != PW'(NPORTS - 1));

    psx_byte_xfer #(
        .CLK_DIV (CLK_DIV)
    ) u_xfer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (xfer_start),
        .tx_byte (psx_tx_byte(xfer_idx)),
        .data    (data),
        .done    (xfer_done),
        .rx_byte (rx_byte),
        .psx_clk (psx_clk),
        .cmd     (cmd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg <= '0;
        end else if (!enable || (timer_reg == TW'(POLL_PERIOD - 1))) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            port_reg  <= '0;
            byte_reg  <= '0;
            bad_reg   <= 1'b0;
            rx3_reg   <= 8'hFF;
            att_n     <= '1;
            btn_valid <= 1'b0;
            btn_port  <= '0;
            btn_word  <= 16'hFFFF;
        end else begin
            btn_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (frame_start) begin
                        port_reg  <= '0;
                        att_n     <= ~NPORTS'(1);
                        cnt_reg   <= '0;
                        state_reg <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (setup_done) begin
                        byte_reg  <= '0;
                        bad_reg   <= 1'b0;
                        state_reg <= ST_XFER;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_XFER: begin
                    if (xfer_done) begin
                        if (id_bad) begin
                            bad_reg <= 1'b1;
                        end
                        if (byte_reg == 3'd3) begin
                            rx3_reg <= rx_byte;
                        end
                        cnt_reg   <= '0;
                        state_reg <= ST_ACK_WAIT;
                    end
                end
                ST_ACK_WAIT: begin
                    if (ack_go) begin
                        byte_reg  <= byte_reg + 3'd1;
                        state_reg <= ST_XFER;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_END: begin
                    cnt_reg   <= CW'(1);
                    state_reg <= ST_GAP;
                end
                ST_GAP: begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Poll completion and port sequencing override the per-state defaults above.
            if (finish_now) begin
                att_n     <= '1;
                state_reg <= ST_END;
                if (finish_clean) begin
                    btn_valid <= 1'b1;
                    btn_port  <= port_reg;
                    btn_word  <= {rx_byte, rx3_reg};
                end
            end
            if (gap_done) begin
                if (advance) begin
                    port_reg  <= port_reg + PW'(1);
                    att_n     <= ~(NPORTS'(1) << (port_reg + PW'(1)));
                    cnt_reg   <= '0;
                    state_reg <= ST_SETUP;
                end else begin
                    state_reg <= ST_IDLE;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        logic present_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                present_reg <= 1'b0;
            end else if (finish_now && (port_reg == PW'(gi))) begin
                present_reg <= finish_clean;
            end
        end
        assign port_present[gi] = present_reg;

`ifdef PSX_ERR_CNT_EN
        logic [7:0] err_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_reg <= 8'h00;
            end else if (finish_now && !finish_clean && (port_reg == PW'(gi)) && (err_reg != 8'hFF)) begin
                err_reg <= err_reg + 8'h01;
            end
        end
        assign err_cnt[8*gi +: 8] = err_reg;
`endif
    end

endmodule
